ckt_vector_checker: RTL and testbench

//  Stimulus/response harness for the four-input logicopt benchmark circuit (inputs a,b,c,d; outputs o1,o2,o3).

---
 rtl/ckt_chk_pkg.sv | 24 ++
 rtl/ckt_vector_checker_if.sv | 37 +++
 rtl/ckt_golden_model.sv | 28 ++
 rtl/ckt_vector_checker.sv | 117 +++++++++++
 tb/tb_ckt_vector_checker.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ckt_chk_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ckt_chk_pkg : shared types and golden functions for ckt_vector_checker     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package ckt_chk_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        SETTLE  = 3'd2,
        COMPARE = 3'd3,
        DONE    = 3'd4
    } state_t;

    localparam int NUM_VEC = 16;

    // v = {a,b,c,d}; result = {o1,o2,o3}
    function automatic logic [2:0] golden(input logic [3:0] v);
        return {1'b0, ~v[2] & ~v[1], ~v[0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/ckt_vector_checker_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ckt_vector_checker_if : control, stimulus and result bundle of the checker |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface ckt_vector_checker_if #(
    parameter int CNT_W = 5
);
    logic             start;
    logic             abort;
    logic             vec_a;
    logic             vec_b;
    logic             vec_c;
    logic             vec_d;
    logic             dut_o1;
    logic             dut_o2;
    logic             dut_o3;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [3:0]       first_fail_vec;
    logic             first_fail_vld;

    modport master (
        input  start, abort, dut_o1, dut_o2, dut_o3,
        output vec_a, vec_b, vec_c, vec_d, busy, done, pass,
               err_count, first_fail_vec, first_fail_vld
    );

    modport slave (
        output start, abort, dut_o1, dut_o2, dut_o3,
        input  vec_a, vec_b, vec_c, vec_d, busy, done, pass,
               err_count, first_fail_vec, first_fail_vld
    );
endinterface
`default_nettype wire

// File: rtl/ckt_golden_model.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ckt_golden_model : optimised reference functions o1=0, o2=~b&~c, o3=~d     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ckt_golden_model (
    input  logic [3:0] vec,
    output logic [2:0] expected
);
    wire w_na;
    wire w_nb;
    wire w_nc;
    wire w_o1;
    wire w_o2;
    wire w_o3;

    not u_not_a (w_na, vec[3]);
    not u_not_b (w_nb, vec[2]);
    not u_not_c (w_nc, vec[1]);
    not u_not_d (w_o3, vec[0]);

    // a & ~a keeps o1 a real cell output tied to an input rather than a constant
    and u_and_o1 (w_o1, vec[3], w_na);
    and u_and_o2 (w_o2, w_nb, w_nc);

    assign expected = {w_o1, w_o2, w_o3};
endmodule
`default_nettype wire

// File: rtl/ckt_vector_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ckt_vector_checker : drives all 16 vectors, compares against golden model  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module ckt_vector_checker
    import ckt_chk_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    ckt_vector_checker_if.master  bus
);
    localparam bit         c_has_settle  = (SETTLE_CYCLES > 0);
    localparam logic [3:0] c_settle_last = (SETTLE_CYCLES > 0) ? 4'(SETTLE_CYCLES - 1) : 4'd0;
    localparam logic [3:0] c_last_idx    = 4'(NUM_VEC - 1);

    state_t           r_state;
    logic [3:0]       r_idx;
    logic [3:0]       r_cnt;
    logic [CNT_W-1:0] r_err;
    logic [3:0]       r_ff_vec;
    logic             r_ff_vld;
    logic             r_busy;
    logic             r_done;
    logic [2:0]       w_expected;
    logic             w_mismatch;

    ckt_golden_model u_golden (
        .vec      (r_idx),
        .expected (w_expected)
    );

    assign w_mismatch = ({bus.dut_o1, bus.dut_o2, bus.dut_o3} != w_expected);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= IDLE;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_err    <= '0;
            r_ff_vec <= '0;
            r_ff_vld <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (r_busy && bus.abort) begin
            // partial error bookkeeping is kept for inspection after an abort
            r_state <= IDLE;
            r_idx   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (bus.start && !bus.abort) begin
                        r_state  <= DRIVE;
                        r_idx    <= '0;
                        r_err    <= '0;
                        r_ff_vec <= '0;
                        r_ff_vld <= 1'b0;
                        r_busy   <= 1'b1;
                        r_done   <= 1'b0;
                    end
                end
                DRIVE: begin
                    r_cnt   <= '0;
                    r_state <= c_has_settle ? SETTLE : COMPARE;
                end
                SETTLE: begin
                    if (r_cnt == c_settle_last) begin
                        r_state <= COMPARE;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                COMPARE: begin
                    if (w_mismatch) begin
                        r_err <= r_err + CNT_W'(1);
                        if (!r_ff_vld) begin
                            r_ff_vec <= r_idx;
                            r_ff_vld <= 1'b1;
                        end
                    end
                    if (r_idx == c_last_idx) begin
                        r_state <= DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_state <= DRIVE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_idx   <= '0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.vec_a          = r_idx[3];
    assign bus.vec_b          = r_idx[2];
    assign bus.vec_c          = r_idx[1];
    assign bus.vec_d          = r_idx[0];
    assign bus.busy           = r_busy;
    assign bus.done           = r_done;
    assign bus.pass           = r_done && (r_err == '0);
    assign bus.err_count      = r_err;
    assign bus.first_fail_vec = r_ff_vec;
    assign bus.first_fail_vld = r_ff_vld;

endmodule
`default_nettype wire

// File: tb/tb_ckt_vector_checker.sv
`default_nettype none
// Bench for ckt_vector_checker: two instances (settle 2 and settle 0) driving a
// configurable circuit-under-test model, checked every cycle against a run-time model.
module tb_ckt_vector_checker;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   fault_mode = 0;   // 0 golden, 1 o3=d, 2 o1 stuck-1 at 4'b1111
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    ckt_vector_checker_if #(.CNT_W(5)) if2 ();
    ckt_vector_checker_if #(.CNT_W(5)) if0 ();

    ckt_vector_checker #(.SETTLE_CYCLES(2), .CNT_W(5)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));
    ckt_vector_checker #(.SETTLE_CYCLES(0), .CNT_W(5)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));

    // circuit under test, per fault mode
    function automatic logic [2:0] cut_out(int mode, logic [3:0] v);
        logic o1, o2, o3;
        o1 = (mode == 2) && (v == 4'hF);
        o2 = !v[2] && !v[1];
        o3 = (mode == 1) ? v[0] : !v[0];
        return {o1, o2, o3};
    endfunction

    function automatic logic [2:0] ref_out(logic [3:0] v);
        return {1'b0, !v[2] && !v[1], !v[0]};
    endfunction

    always_comb {if2.dut_o1, if2.dut_o2, if2.dut_o3} = cut_out(fault_mode, {if2.vec_a, if2.vec_b, if2.vec_c, if2.vec_d});
    always_comb {if0.dut_o1, if0.dut_o2, if0.dut_o3} = cut_out(fault_mode, {if0.vec_a, if0.vec_b, if0.vec_c, if0.vec_d});

    // ---------------- behavioural model ----------------
    function automatic int period(int i);
        return (i == 0) ? 4 : 2;
    endfunction

    function automatic logic inst_start(int i);
        return (i == 0) ? if2.start : if0.start;
    endfunction

    function automatic logic inst_abort(int i);
        return (i == 0) ? if2.abort : if0.abort;
    endfunction

    // vectors j whose compare edge ((j+1)*p cycles after start) has passed by time t
    function automatic int fail_count(int p, int t);
        int n = 0;
        for (int j = 0; j < 16; j++)
            if ((j + 1) * p <= t && cut_out(fault_mode, 4'(j)) != ref_out(4'(j))) n++;
        return n;
    endfunction

    function automatic int first_fail(int p, int t);
        for (int j = 0; j < 16; j++)
            if ((j + 1) * p <= t && cut_out(fault_mode, 4'(j)) != ref_out(4'(j))) return j;
        return 0;
    endfunction

    int m_phase[2] = '{0, 0};   // 0 idle, 1 running, 2 finished
    int m_t[2]     = '{0, 0};   // cycles since accepted start
    int m_err[2]   = '{0, 0};
    int m_ff[2]    = '{0, 0};
    int m_ffv[2]   = '{0, 0};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                m_phase[i] <= 0; m_t[i] <= 0; m_err[i] <= 0; m_ff[i] <= 0; m_ffv[i] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (m_phase[i] == 1) begin
                    if (inst_abort(i)) begin
                        m_phase[i] <= 0;
                        m_t[i]     <= 0;
                    end else begin
                        m_t[i]   <= m_t[i] + 1;
                        m_err[i] <= fail_count(period(i), m_t[i] + 1);
                        m_ff[i]  <= first_fail(period(i), m_t[i] + 1);
                        m_ffv[i] <= (fail_count(period(i), m_t[i] + 1) > 0) ? 1 : 0;
                        if (m_t[i] + 1 == 16 * period(i)) m_phase[i] <= 2;
                    end
                end else if (inst_start(i) && !inst_abort(i)) begin
                    m_phase[i] <= 1; m_t[i] <= 0; m_err[i] <= 0; m_ff[i] <= 0; m_ffv[i] <= 0;
                end
            end
        end
    end

    task automatic check(string name, int act, int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    task automatic cmp(int i, logic busy, logic done, logic pass, logic [3:0] vec,
                       logic [4:0] err, logic [3:0] ff, logic ffv);
        string s;
        int    ev;
        s  = (i == 0) ? "s2" : "s0";
        ev = (m_phase[i] == 0) ? 0 : ((m_t[i] / period(i)) > 15 ? 15 : m_t[i] / period(i));
        check({s, "_busy"}, busy, (m_phase[i] == 1) ? 1 : 0);
        check({s, "_done"}, done, (m_phase[i] == 2) ? 1 : 0);
        check({s, "_pass"}, pass, (m_phase[i] == 2 && m_err[i] == 0) ? 1 : 0);
        check({s, "_vec"}, vec, ev);
        check({s, "_err"}, err, m_err[i]);
        check({s, "_ffvec"}, ff, m_ff[i]);
        check({s, "_ffvld"}, ffv, m_ffv[i]);
    endtask

    always @(posedge clk) begin
        #1;
        cmp(0, if2.busy, if2.done, if2.pass, {if2.vec_a, if2.vec_b, if2.vec_c, if2.vec_d},
            if2.err_count, if2.first_fail_vec, if2.first_fail_vld);
        cmp(1, if0.busy, if0.done, if0.pass, {if0.vec_a, if0.vec_b, if0.vec_c, if0.vec_d},
            if0.err_count, if0.first_fail_vec, if0.first_fail_vld);
    end

    // ---------------- directed sequence ----------------
    task automatic set_start(int i, logic v);
        if (i == 0) if2.start = v; else if0.start = v;
    endtask

    function automatic logic inst_done(int i);
        return (i == 0) ? if2.done : if0.done;
    endfunction

    // pulse start, return number of edges from acceptance until done is seen
    task automatic run(int i, int extra_at, output int n);
        @(negedge clk) set_start(i, 1'b1);
        @(posedge clk);
        n = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk) set_start(i, (c + 1 == extra_at) ? 1'b1 : 1'b0);
            @(posedge clk);
            #1;
            n++;
            if (inst_done(i)) break;
        end
        @(negedge clk) set_start(i, 1'b0);
    endtask

    task automatic wait_vec(int v);
        int c;
        for (c = 0; c < 100; c++) begin
            if ({if2.vec_a, if2.vec_b, if2.vec_c, if2.vec_d} == 4'(v) && if2.busy) break;
            @(posedge clk);
            #1;
        end
        check("wait_vec_timeout", (c < 100) ? 1 : 0, 1);
    endtask

    int lat;

    initial begin
        if2.start = 1'b0; if2.abort = 1'b0;
        if0.start = 1'b0; if0.abort = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_busy", if2.busy, 0);
        check("rst_done", if2.done, 0);
        check("rst_vec", {if2.vec_a, if2.vec_b, if2.vec_c, if2.vec_d}, 0);
        check("rst_err", if2.err_count, 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: golden circuit
        fault_mode = 0;
        run(0, 0, lat);
        check("t1_latency", lat, 64);
        check("t1_err", if2.err_count, 0);
        check("t1_pass", if2.pass, 1);
        check("t1_ffvld", if2.first_fail_vld, 0);

        // 2: o3 inverted, restart from DONE
        fault_mode = 1;
        run(0, 0, lat);
        check("t2_err", if2.err_count, 16);
        check("t2_pass", if2.pass, 0);
        check("t2_ffvec", if2.first_fail_vec, 0);
        check("t2_ffvld", if2.first_fail_vld, 1);

        // 3: o1 stuck-1 only at 1111
        fault_mode = 2;
        run(0, 0, lat);
        check("t3_err", if2.err_count, 1);
        check("t3_ffvec", if2.first_fail_vec, 15);
        check("t3_pass", if2.pass, 0);

        // 4: no settle cycles
        fault_mode = 0;
        run(1, 0, lat);
        check("t4_latency", lat, 32);
        check("t4_pass", if0.pass, 1);

        // 5: abort at idx 5 in SETTLE, then clean rerun
        @(negedge clk) if2.start = 1'b1;
        @(negedge clk) if2.start = 1'b0;
        wait_vec(5);
        @(posedge clk);
        #1;
        @(negedge clk) if2.abort = 1'b1;
        @(posedge clk);
        #1;
        check("t5_abort_busy", if2.busy, 0);
        check("t5_abort_done", if2.done, 0);
        check("t5_abort_vec", {if2.vec_a, if2.vec_b, if2.vec_c, if2.vec_d}, 0);
        @(negedge clk) if2.abort = 1'b0;
        run(0, 0, lat);
        check("t5_latency", lat, 64);
        check("t5_pass", if2.pass, 1);

        // 6: start while busy ignored; reset during COMPARE of idx 9
        run(0, 10, lat);
        check("t6_latency_busy_start", lat, 64);
        fault_mode = 1;
        @(negedge clk) if2.start = 1'b1;
        @(negedge clk) if2.start = 1'b0;
        wait_vec(9);
        repeat (3) @(posedge clk);
        #2;
        check("t6_pre_rst_err", if2.err_count, 9);
        rst_n = 1'b0;
        #1;
        check("t6_rst_busy", if2.busy, 0);
        check("t6_rst_done", if2.done, 0);
        check("t6_rst_vec", {if2.vec_a, if2.vec_b, if2.vec_c, if2.vec_d}, 0);
        check("t6_rst_err", if2.err_count, 0);
        check("t6_rst_ffvld", if2.first_fail_vld, 0);
        @(negedge clk) rst_n = 1'b1;
        fault_mode = 0;
        run(0, 0, lat);
        check("t6_rerun_latency", lat, 64);
        check("t6_rerun_pass", if2.pass, 1);

        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
